// File: rtl/intensity_window_ctrl_if.sv
// Pixel read port between the window sequencer and the frame SRAM controller.
// The master issues req/addr and holds them until ack returns with read data.
interface intensity_window_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              pixel_req;
    logic [ADDR_W-1:0] pixel_addr;
    logic              pixel_ack;
    logic [23:0]       pixel_rdata;

    modport master (
        output pixel_req,
        output pixel_addr,
        input  pixel_ack,
        input  pixel_rdata
    );

    modport slave (
        input  pixel_req,
        input  pixel_addr,
        output pixel_ack,
        output pixel_rdata
    );
endinterface

// File: rtl/intensity_window_ctrl.sv
// 3x3 window sequencer feeding the intensity and edge-detect blocks.
// Define SLIDE_REUSE_EN to reuse two window columns when stepping along a row.
module intensity_window_ctrl #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int ADDR_W      = 19,
    parameter int INT_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    intensity_window_ctrl_if.master mem,
    output logic [215:0]            pixelData,
    output logic                    intensity_enable,
    output logic                    edgedetect_enable,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int LW = $clog2(INT_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        INTEN,
        WAIT,
        EDGE,
        ADVANCE,
        DONE
    } state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [3:0]      k;
    logic [LW-1:0]   cnt;
    logic [3:0]      k_step;

    function automatic logic [1:0] k_row(input logic [3:0] kk);
        logic [1:0] kr;
        kr = 2'd0;
        unique case (1'b1)
            (kk < 4'd3):                kr = 2'd0;
            (kk >= 4'd3 && kk < 4'd6): kr = 2'd1;
            default:                    kr = 2'd2;
        endcase
        return kr;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic [RW-1:0] r,
        input logic [CW-1:0] c,
        input logic [3:0]    kk
    );
        logic [1:0]        kr;
        logic [3:0]        kc;
        logic [ADDR_W-1:0] ar;
        logic [ADDR_W-1:0] ac;
        kr = k_row(kk);
        kc = kk - {1'b0, kr, 1'b0} - {2'b00, kr};
        ar = ADDR_W'(r) + ADDR_W'(kr) - ADDR_W'(1);
        ac = ADDR_W'(c) + ADDR_W'(kc) - ADDR_W'(1);
        return ar * ADDR_W'(IMG_WIDTH) + ac;
    endfunction

    function automatic logic [215:0] put_slot(
        input logic [215:0] d,
        input logic [3:0]   kk,
        input logic [23:0]  px
    );
        logic [215:0] s;
        s = d;
        for (int j = 0; j < 9; j++) begin
            if (kk == 4'(j)) s[215-24*j -: 24] = px;
        end
        return s;
    endfunction

`ifdef SLIDE_REUSE_EN
    logic skip;

    // Slide the window one column left; the right column is refetched.
    function automatic logic [215:0] shift_win(input logic [215:0] d);
        logic [215:0] s;
        s = d;
        for (int i = 0; i < 3; i++) begin
            s[215-72*i -: 24] = d[191-72*i -: 24];
            s[191-72*i -: 24] = d[167-72*i -: 24];
        end
        return s;
    endfunction

    assign k_step = skip ? 4'd3 : 4'd1;
`else
    assign k_step = 4'd1;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state             <= IDLE;
            row               <= RW'(1);
            col               <= CW'(1);
            k                 <= 4'd0;
            cnt               <= '0;
            mem.pixel_req     <= 1'b0;
            mem.pixel_addr    <= '0;
            pixelData         <= '0;
            intensity_enable  <= 1'b0;
            edgedetect_enable <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
`ifdef SLIDE_REUSE_EN
            skip              <= 1'b0;
`endif
        end else begin
            intensity_enable  <= 1'b0;
            edgedetect_enable <= 1'b0;
            done              <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= FETCH;
                        row            <= RW'(1);
                        col            <= CW'(1);
                        k              <= 4'd0;
                        mem.pixel_req  <= 1'b1;
                        mem.pixel_addr <= addr_of(RW'(1), CW'(1), 4'd0);
                        busy           <= 1'b1;
`ifdef SLIDE_REUSE_EN
                        skip           <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (mem.pixel_ack) begin
                        pixelData <= put_slot(pixelData, k, mem.pixel_rdata);
                        if (k == 4'd8) begin
                            state            <= INTEN;
                            mem.pixel_req    <= 1'b0;
                            intensity_enable <= 1'b1;
                        end else begin
                            k              <= k + k_step;
                            mem.pixel_addr <= addr_of(row, col, k + k_step);
                        end
                    end
                end
                INTEN: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (cnt == LW'(INT_LATENCY - 1)) begin
                        state             <= EDGE;
                        edgedetect_enable <= 1'b1;
                    end else begin
                        cnt <= cnt + LW'(1);
                    end
                end
                EDGE: begin
                    state <= ADVANCE;
                end
                ADVANCE: begin
                    if (col < CW'(IMG_WIDTH - 2)) begin
                        state         <= FETCH;
                        col           <= col + CW'(1);
                        mem.pixel_req <= 1'b1;
`ifdef SLIDE_REUSE_EN
                        k              <= 4'd2;
                        skip           <= 1'b1;
                        pixelData      <= shift_win(pixelData);
                        mem.pixel_addr <= addr_of(row, col + CW'(1), 4'd2);
`else
                        k              <= 4'd0;
                        mem.pixel_addr <= addr_of(row, col + CW'(1), 4'd0);
`endif
                    end else if (row == RW'(IMG_HEIGHT - 2)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state          <= FETCH;
                        row            <= row + RW'(1);
                        col            <= CW'(1);
                        k              <= 4'd0;
                        mem.pixel_req  <= 1'b1;
                        mem.pixel_addr <= addr_of(row + RW'(1), CW'(1), 4'd0);
`ifdef SLIDE_REUSE_EN
                        skip           <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    row   <= RW'(1);
                    col   <= CW'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intensity_window_ctrl.sv
// Bench for intensity_window_ctrl on a 4x4 frame with a behavioural memory
// responder and a coordinate-level model of the expected window stream.
module tb_intensity_window_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 16;
    localparam int L    = 2;
    localparam int NWIN = (W - 2) * (H - 2);
`ifdef SLIDE_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    typedef struct {
        int            k;
        logic [AW-1:0] addr;
    } fetch_vec_t;

    typedef struct {
        int          r;
        int          c;
        logic [23:0] tag;
    } ctr_vec_t;

    logic         tb_clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [215:0] pixelData;
    logic         intensity_enable;
    logic         edgedetect_enable;
    logic         busy;
    logic         done;

    intensity_window_ctrl_if #(.ADDR_W(AW)) mem ();

    intensity_window_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_W     (AW),
        .INT_LATENCY(L)
    ) dut (
        .clk              (tb_clk),
        .n_rst            (n_rst),
        .start            (start),
        .mem              (mem),
        .pixelData        (pixelData),
        .intensity_enable (intensity_enable),
        .edgedetect_enable(edgedetect_enable),
        .busy             (busy),
        .done             (done)
    );

    always #5 tb_clk = ~tb_clk;

    int n_chk = 0;
    int n_fail = 0;

    int            wr[$];
    int            wc[$];
    logic [AW-1:0] exp_fetch[$];
    int            fetch_end[$];

    bit            mon_on = 1'b0;
    int            ack_mode = 0;
    int            stall_left = 0;
    int            cyc = 0;
    int            n_acks, n_int, n_edge, n_done;
    int            last_ack_cyc = -10;
    int            last_int_cyc = -10;
    logic          prev_req = 1'b0;
    logic          prev_ack = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] cap_addr[$];
    logic [23:0]   cap_ctr[$];

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] pix_addr(int r, int c, int k);
        return AW'((r - 1 + k / 3) * W + (c - 1 + k % 3));
    endfunction

    function automatic logic [23:0] tag(logic [AW-1:0] a);
        return {8'hA, a[15:0]};
    endfunction

    function automatic logic [215:0] exp_window(int r, int c);
        logic [215:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[215-24*k -: 24] = tag(pix_addr(r, c, k));
        return w;
    endfunction

    task automatic build_model();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                wr.push_back(r);
                wc.push_back(c);
                for (int k = 0; k < 9; k++) begin
                    if (REUSE && c > 1 && (k % 3) != 2) continue;
                    exp_fetch.push_back(pix_addr(r, c, k));
                end
                fetch_end.push_back(exp_fetch.size());
            end
        end
    endtask

    task automatic monitor_step();
        if (prev_req && !prev_ack) begin
            check("req_hold", mem.pixel_req, 1);
            check("addr_hold", mem.pixel_addr, prev_addr);
        end
        if (intensity_enable) begin
            if (n_int < NWIN) begin
                check("int_data", pixelData, exp_window(wr[n_int], wc[n_int]));
                check("int_after_ack", last_ack_cyc, cyc - 1);
                check("int_fetch_cnt", n_acks, fetch_end[n_int]);
            end else begin
                check("int_extra", n_int, NWIN - 1);
            end
            cap_ctr.push_back(pixelData[215-24*4 -: 24]);
            last_int_cyc = cyc;
            n_int++;
        end
        if (edgedetect_enable) begin
            check("edge_delay", cyc - last_int_cyc, L + 1);
            n_edge++;
            check("edge_order", n_edge, n_int);
        end
        if (done) begin
            n_done++;
            check("done_after_edge", n_edge, NWIN);
        end
    endtask

    task automatic drive_ack();
        logic a;
        prev_req  = mem.pixel_req;
        prev_addr = mem.pixel_addr;
        if (ack_mode == 0) a = 1'b1;
        else if (!mem.pixel_req) a = 1'($urandom_range(0, 1));
        else if (stall_left > 0) begin
            a = 1'b0;
            stall_left--;
        end else begin
            a = 1'b1;
            stall_left = $urandom_range(0, 5);
        end
        if (mon_on && mem.pixel_req && a) begin
            if (n_acks < exp_fetch.size())
                check("fetch_addr", mem.pixel_addr, exp_fetch[n_acks]);
            else
                check("fetch_extra", n_acks, exp_fetch.size() - 1);
            cap_addr.push_back(mem.pixel_addr);
            n_acks++;
            last_ack_cyc = cyc;
        end
        prev_ack        = a;
        mem.pixel_ack   = a;
        mem.pixel_rdata = tag(mem.pixel_addr);
    endtask

    initial begin
        mem.pixel_ack   = 1'b0;
        mem.pixel_rdata = '0;
        forever begin
            @(negedge tb_clk);
            cyc++;
            if (mon_on) monitor_step();
            drive_ack();
        end
    end

    task automatic run_pass(input int mode, input bit poke);
        n_acks = 0;
        n_int  = 0;
        n_edge = 0;
        n_done = 0;
        cap_addr.delete();
        cap_ctr.delete();
        stall_left = 0;
        ack_mode = mode;
        mon_on = 1'b1;
        @(negedge tb_clk);
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        for (int i = 0; i < 4000 && n_done == 0; i++) begin
            @(negedge tb_clk);
            if (poke && i == 30) begin
                check("busy_when_poked", busy, 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (20) @(negedge tb_clk);
        check("pass_done", n_done, 1);
        check("pass_int", n_int, NWIN);
        check("pass_edge", n_edge, NWIN);
        check("pass_acks", n_acks, exp_fetch.size());
        check("pass_idle", busy, 0);
        mon_on = 1'b0;
    endtask

    fetch_vec_t fvec[9];
    ctr_vec_t   cvec[4];
    int         quiet;

    initial begin
        fvec[0] = '{0, 16'd0};
        fvec[1] = '{1, 16'd1};
        fvec[2] = '{2, 16'd2};
        fvec[3] = '{3, 16'd4};
        fvec[4] = '{4, 16'd5};
        fvec[5] = '{5, 16'd6};
        fvec[6] = '{6, 16'd8};
        fvec[7] = '{7, 16'd9};
        fvec[8] = '{8, 16'd10};
        cvec[0] = '{1, 1, {8'hA, 16'd5}};
        cvec[1] = '{1, 2, {8'hA, 16'd6}};
        cvec[2] = '{2, 1, {8'hA, 16'd9}};
        cvec[3] = '{2, 2, {8'hA, 16'd10}};
        build_model();

        n_rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge tb_clk);
        check("rst_req", mem.pixel_req, 0);
        check("rst_addr", mem.pixel_addr, 0);
        check("rst_data", pixelData, 0);
        check("rst_int", intensity_enable, 0);
        check("rst_edge", edgedetect_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        n_rst = 1'b1;

        run_pass(0, 1'b0);
        for (int i = 0; i < 9; i++)
            check($sformatf("win11_k%0d", fvec[i].k),
                  (i < cap_addr.size()) ? cap_addr[i] : 'x, fvec[i].addr);
        for (int i = 0; i < 4; i++)
            check($sformatf("centre_%0d_%0d", cvec[i].r, cvec[i].c),
                  (i < cap_ctr.size()) ? cap_ctr[i] : 'x, cvec[i].tag);

        run_pass(1, 1'b1);

        // Abort a pass from inside FETCH with an asynchronous reset.
        ack_mode = 1;
        @(negedge tb_clk);
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !(mem.pixel_req && busy); i++)
            @(negedge tb_clk);
        check("abort_in_fetch", mem.pixel_req, 1);
        #2 n_rst = 1'b0;
        #1;
        check("abort_req", mem.pixel_req, 0);
        check("abort_busy", busy, 0);
        check("abort_data", pixelData, 0);
        check("abort_addr", mem.pixel_addr, 0);
        repeat (3) @(negedge tb_clk);
        n_rst = 1'b1;
        quiet = 0;
        repeat (30) begin
            @(negedge tb_clk);
            if (intensity_enable || edgedetect_enable || done ||
                mem.pixel_req || busy) quiet++;
        end
        check("no_pulse_after_reset", quiet, 0);

        run_pass(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
